// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared types and constants for the 3x3 convolution sequencer.
//   seq_state_t  : sequencer FSM states
//   CTRL_*       : kernel ctrl bus encodings for the LOADW / LO / HI phases
//   seq_tag_t    : per-cycle tag that travels alongside the kernel latency
//   loadw_nibble : selects which PE weight is on the row bus in a LOADW cycle
package conv_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADW = 3'd1,
        S_LO    = 3'd2,
        S_HI    = 3'd3,
        S_DRAIN = 3'd4,
        S_FIN   = 3'd5
    } seq_state_t;

    localparam logic [3:0] CTRL_LOADW = 4'b0001;
    localparam logic [3:0] CTRL_LO    = 4'b0010;
    localparam logic [3:0] CTRL_HI    = 4'b0100;

    localparam int LOADW_CYC   = 5;
    localparam int MIN_WIN_IDX = 2;

    // Wide enough for any practical row length; the top zero-extends its index.
    localparam int TAG_IDX_W = 16;

    typedef struct packed {
        logic                 valid;
        logic                 phase;  // 0 = LSB byte, 1 = MSB byte
        logic [TAG_IDX_W-1:0] idx;
    } seq_tag_t;

    // Weights shift through the PE chain, so the far PE (PE3) is sent first.
    function automatic logic [3:0] loadw_nibble(input logic [11:0] w, input logic [2:0] cyc);
        if (cyc < 3'd2)      return w[11:8];
        else if (cyc < 3'd4) return w[7:4];
        else                 return w[3:0];
    endfunction

endpackage

// File: rtl/conv_seq_tag_pipe.sv
// conv_seq_tag_pipe: DEPTH-stage tag delay line matching the kernel latency.
//   clk      : clock
//   rst      : synchronous active-high reset
//   clr      : synchronous clear (start of frame)
//   push_tag : tag entering this cycle (one push every cycle)
//   tail     : tag that entered DEPTH cycles ago
//   empty    : no valid tag anywhere in the line
module conv_seq_tag_pipe
    import conv_seq_pkg::*;
#(
    parameter int DEPTH = 7
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     clr,
    input  seq_tag_t push_tag,
    output seq_tag_t tail,
    output logic     empty
);

    seq_tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= push_tag;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            if (stage[i].valid) empty = 1'b0;
    end

    assign tail = stage[DEPTH-1];

endmodule

// File: rtl/conv3x3_sequencer.sv
// conv3x3_sequencer: control sequencer for the bit-serial 3x3 systolic kernel.
// Loads 9 weights, streams pixel triples as LO/HI byte phases, drives the
// kernel ctrl bus and rebuilds 16-bit window sums from the byte-serial result.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start                : begin a frame (IDLE only)
//   w_row1..3            : per-row weights {PE3,PE2,PE1}, each {negate, shift[2:0]}
//   px_valid/px_ready    : pixel triple handshake, px1..3 pixel per row
//   pe_in1..3, pe_ctrl   : kernel row inputs and ctrl {carry, hold-x, LSB, StoreW}
//   pe_res               : kernel result byte
//   y_valid/y_data/y_index : assembled window sum and its rightmost column
//   busy, done, err      : frame status; err is a sticky pixel-underrun flag
//   stall_cnt            : underrun cycle count, only with CONV_SEQ_STALL_CNT_EN
// Build option: define CONV_SEQ_STALL_CNT_EN to add the stall_cnt output.
module conv3x3_sequencer
    import conv_seq_pkg::*;
#(
    parameter int N_PIX   = 16,
    parameter int RES_LAT = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [11:0]              w_row1,
    input  logic [11:0]              w_row2,
    input  logic [11:0]              w_row3,
    input  logic                     px_valid,
    output logic                     px_ready,
    input  logic [7:0]               px1,
    input  logic [7:0]               px2,
    input  logic [7:0]               px3,
    output logic [7:0]               pe_in1,
    output logic [7:0]               pe_in2,
    output logic [7:0]               pe_in3,
    output logic [3:0]               pe_ctrl,
    input  logic [7:0]               pe_res,
    output logic                     y_valid,
    output logic [15:0]              y_data,
    output logic [$clog2(N_PIX)-1:0] y_index,
    output logic                     busy,
    output logic                     done,
`ifdef CONV_SEQ_STALL_CNT_EN
    output logic [15:0]              stall_cnt,
`endif
    output logic                     err
);

    localparam int IDX_W = $clog2(N_PIX);

    seq_state_t       state;
    logic [2:0]       ld_cnt;
    logic [IDX_W-1:0] idx;
    logic [11:0]      w1_q, w2_q, w3_q;
    logic [7:0]       px1_q, px2_q, px3_q;
    logic             drn_ph;
    logic [7:0]       lo_byte;
    logic [3:0]       ctrl_base;
    logic             start_acc;
    seq_tag_t         push_tag, tail;
    logic             pipe_empty;

    assign start_acc = (state == S_IDLE) && start;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ld_cnt <= '0;
            idx    <= '0;
            w1_q   <= '0;
            w2_q   <= '0;
            w3_q   <= '0;
            px1_q  <= '0;
            px2_q  <= '0;
            px3_q  <= '0;
            drn_ph <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    w1_q   <= w_row1;
                    w2_q   <= w_row2;
                    w3_q   <= w_row3;
                    err    <= 1'b0;
                    ld_cnt <= '0;
                    idx    <= '0;
                    state  <= S_LOADW;
                end
                S_LOADW: begin
                    if (ld_cnt == 3'(LOADW_CYC - 1)) state <= S_LO;
                    else                             ld_cnt <= ld_cnt + 3'd1;
                end
                S_LO: begin
                    // Underrun never stalls the frame: a zero pixel goes in instead.
                    px1_q <= px_valid ? px1 : 8'h00;
                    px2_q <= px_valid ? px2 : 8'h00;
                    px3_q <= px_valid ? px3 : 8'h00;
                    if (!px_valid) err <= 1'b1;
                    state <= S_HI;
                end
                S_HI: begin
                    if (idx == IDX_W'(N_PIX - 1)) begin
                        drn_ph <= 1'b0;
                        state  <= S_DRAIN;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_LO;
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty) state <= S_FIN;
                    else            drn_ph <= ~drn_ph;
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CONV_SEQ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || start_acc)
            stall_cnt <= '0;
        else if (state == S_LO && !px_valid && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

    // ------------------------------------------------------ kernel drive
    always_comb begin
        ctrl_base = 4'b0000;
        pe_in1    = 8'h00;
        pe_in2    = 8'h00;
        pe_in3    = 8'h00;
        px_ready  = 1'b0;
        case (state)
            S_LOADW: begin
                ctrl_base = CTRL_LOADW;
                pe_in1    = {4'h0, loadw_nibble(w1_q, ld_cnt)};
                pe_in2    = {4'h0, loadw_nibble(w2_q, ld_cnt)};
                pe_in3    = {4'h0, loadw_nibble(w3_q, ld_cnt)};
            end
            S_LO: begin
                ctrl_base = CTRL_LO;
                px_ready  = 1'b1;
                pe_in1    = px_valid ? px1 : 8'h00;
                pe_in2    = px_valid ? px2 : 8'h00;
                pe_in3    = px_valid ? px3 : 8'h00;
            end
            S_HI: begin
                ctrl_base = CTRL_HI;
                pe_in1    = px1_q;
                pe_in2    = px2_q;
                pe_in3    = px3_q;
            end
            S_DRAIN: ctrl_base = drn_ph ? CTRL_HI : CTRL_LO;
            default: ;
        endcase
    end

    // Bit 3 tells the kernel the byte leaving it is the MSB and needs the LSB carry.
    assign pe_ctrl = {tail.valid & tail.phase & (state != S_LOADW), ctrl_base[2:0]};
    assign busy    = (state == S_LOADW) || (state == S_LO) || (state == S_HI) || (state == S_DRAIN);
    assign done    = (state == S_FIN);

    // --------------------------------------------------------- tag pipe
    always_comb begin
        push_tag = '0;
        if (state == S_LO) push_tag = '{valid: 1'b1, phase: 1'b0, idx: TAG_IDX_W'(idx)};
        if (state == S_HI) push_tag = '{valid: 1'b1, phase: 1'b1, idx: TAG_IDX_W'(idx)};
    end

    conv_seq_tag_pipe #(.DEPTH(RES_LAT)) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_acc),
        .push_tag (push_tag),
        .tail     (tail),
        .empty    (pipe_empty)
    );

    // ----------------------------------------------------- result build
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_byte <= '0;
            y_valid <= 1'b0;
            y_data  <= '0;
            y_index <= '0;
        end else begin
            y_valid <= 1'b0;
            if (tail.valid && !tail.phase) lo_byte <= pe_res;
            // Columns 0 and 1 only see a partial window, so they are not published.
            if (tail.valid && tail.phase && tail.idx >= TAG_IDX_W'(MIN_WIN_IDX)) begin
                y_valid <= 1'b1;
                y_data  <= {pe_res, lo_byte};
                y_index <= tail.idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_sequencer.sv
// tb_conv3x3_sequencer: self-checking bench for conv3x3_sequencer.
// A behavioural kernel answers on pe_res from the frame timeline, and every
// output is compared each cycle against that timeline and the window sums.
module tb_conv3x3_sequencer;

    localparam int N_PIX     = 4;
    localparam int RES_LAT   = 7;
    localparam int IDX_W     = $clog2(N_PIX);
    localparam int FRAME_LEN = 8 + 2*N_PIX + RES_LAT;  // start cycle .. FIN inclusive

    logic             clk = 1'b0;
    logic             rst, start, px_valid;
    logic [11:0]      w_row1, w_row2, w_row3;
    logic [7:0]       px1, px2, px3, pe_res;
    logic             px_ready, y_valid, busy, done, err;
    logic [7:0]       pe_in1, pe_in2, pe_in3;
    logic [3:0]       pe_ctrl;
    logic [15:0]      y_data;
    logic [IDX_W-1:0] y_index;
`ifdef CONV_SEQ_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    always #5 clk = ~clk;

    conv3x3_sequencer #(.N_PIX(N_PIX), .RES_LAT(RES_LAT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .w_row1(w_row1), .w_row2(w_row2), .w_row3(w_row3),
        .px_valid(px_valid), .px_ready(px_ready),
        .px1(px1), .px2(px2), .px3(px3),
        .pe_in1(pe_in1), .pe_in2(pe_in2), .pe_in3(pe_in3),
        .pe_ctrl(pe_ctrl), .pe_res(pe_res),
        .y_valid(y_valid), .y_data(y_data), .y_index(y_index),
        .busy(busy), .done(done),
`ifdef CONV_SEQ_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .err(err)
    );

    int n_chk = 0, n_pass = 0;
    int done_seen = 0, frames_done = 0, y_seen = 0;
    logic [15:0] last_y;
    bit prev_err = 0;
    int prev_stall = 0;

    // Frame stimulus: weights per row, pixels per row/column, per-column valid.
    logic [11:0] fw [3];
    logic [7:0]  fpx [3][N_PIX];
    bit          fvalid [N_PIX];

    // Window sum for rightmost column i: PE1 on column i, PE2 on i-1, PE3 on i-2.
    function automatic logic [15:0] win_sum(input int i);
        int acc, term;
        logic [3:0] wv;
        acc = 0;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                if (i - k >= 0) begin
                    wv   = fw[r][4*k +: 4];
                    term = (fvalid[i-k] ? int'(fpx[r][i-k]) : 0) << wv[2:0];
                    acc  = wv[3] ? acc - term : acc + term;
                end
        return 16'(acc);
    endfunction

    task automatic fill(input logic [11:0] w, input logic [7:0] p);
        for (int r = 0; r < 3; r++) begin
            fw[r] = w;
            for (int i = 0; i < N_PIX; i++) fpx[r][i] = p;
        end
        for (int i = 0; i < N_PIX; i++) fvalid[i] = 1'b1;
    endtask

    // Runs one frame starting now; extra_start pulses start while busy,
    // rst_cyc aborts the frame with reset at that cycle (-1 = unused).
    task automatic run_frame(input string nm, input int extra_start, input int rst_cyc);
        logic [15:0] fsum [N_PIX];
        logic [7:0]  e_in [3];
        logic [3:0]  e_ctrl, nib;
        logic        e_rdy, e_busy, e_done, e_err, e_yv;
        int pi, ph, d, t, yi, e_stall, inv_cnt;
        inv_cnt = 0;
        for (int i = 0; i < N_PIX; i++) begin
            fsum[i] = win_sum(i);
            if (!fvalid[i]) inv_cnt++;
        end
        y_seen = 0;
        for (int c = 0; c <= FRAME_LEN + 1; c++) begin
            pi = (c >= 6 && c < 6 + 2*N_PIX) ? (c - 6) / 2 : -1;
            ph = (c >= 6) ? (c - 6) % 2 : 0;
            start  = (c == 0) || (c == extra_start);
            rst    = (c == rst_cyc);
            w_row1 = (c == 0) ? fw[0] : 12'($urandom);
            w_row2 = (c == 0) ? fw[1] : 12'($urandom);
            w_row3 = (c == 0) ? fw[2] : 12'($urandom);
            if (pi >= 0 && ph == 0) begin
                px1 = fpx[0][pi]; px2 = fpx[1][pi]; px3 = fpx[2][pi];
                px_valid = fvalid[pi];
            end else begin
                px1 = 8'($urandom); px2 = 8'($urandom); px3 = 8'($urandom);
                px_valid = 1'($urandom);
            end
            d = c - RES_LAT - 6;
            if (d >= 0 && d < 2*N_PIX) pe_res = (d % 2 == 1) ? fsum[d/2][15:8] : fsum[d/2][7:0];
            else                       pe_res = 8'($urandom);
            @(negedge clk);
            if (c == rst_cyc) begin
                @(posedge clk); #1;
                rst = 1'b0; start = 1'b0; px_valid = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    n_chk++;
                    if ({pe_ctrl, pe_in1, pe_in2, pe_in3, px_ready, busy, done, err, y_valid, y_data, y_index} !== '0)
                        $display("FAIL %s abort_zero +%0d: got ctrl=%b in=%h/%h/%h rdy=%b busy=%b done=%b err=%b yv=%b yd=%h yi=%0d, want all 0",
                                 nm, k, pe_ctrl, pe_in1, pe_in2, pe_in3, px_ready, busy, done, err, y_valid, y_data, y_index);
                    else n_pass++;
`ifdef CONV_SEQ_STALL_CNT_EN
                    n_chk++;
                    if (stall_cnt !== 16'd0) $display("FAIL %s abort_stall: got %0d want 0", nm, stall_cnt);
                    else n_pass++;
`endif
                    @(posedge clk); #1;
                end
                prev_err = 0; prev_stall = 0;
                return;
            end
            // Expected outputs from the frame timeline.
            e_ctrl = 4'b0000;
            for (int r = 0; r < 3; r++) e_in[r] = 8'h00;
            if (c >= 1 && c <= 5) begin
                e_ctrl[2:0] = 3'b001;
                for (int r = 0; r < 3; r++) begin
                    nib = (c - 1 < 2) ? fw[r][11:8] : (c - 1 < 4) ? fw[r][7:4] : fw[r][3:0];
                    e_in[r] = {4'h0, nib};
                end
            end else if (pi >= 0) begin
                e_ctrl[2:0] = (ph == 1) ? 3'b100 : 3'b010;
                for (int r = 0; r < 3; r++) e_in[r] = fvalid[pi] ? fpx[r][pi] : 8'h00;
            end else if (c >= 6 + 2*N_PIX && c <= 6 + 2*N_PIX + RES_LAT) begin
                e_ctrl[2:0] = ((c - 6 - 2*N_PIX) % 2 == 1) ? 3'b100 : 3'b010;
            end
            t = c - RES_LAT - 7;
            e_ctrl[3] = (t >= 0) && (t % 2 == 0) && (t / 2 < N_PIX);
            e_rdy  = (pi >= 0) && (ph == 0);
            e_busy = (c >= 1) && (c <= 6 + 2*N_PIX + RES_LAT);
            e_done = (c == 7 + 2*N_PIX + RES_LAT);
            e_err  = (c == 0) ? prev_err : 1'b0;
            e_stall = (c == 0) ? prev_stall : 0;
            if (c > 0)
                for (int i = 0; i < N_PIX; i++)
                    if (!fvalid[i] && 6 + 2*i < c) begin e_err = 1'b1; e_stall++; end
            t  = c - RES_LAT - 8;
            yi = t / 2;
            e_yv = (t >= 0) && (t % 2 == 0) && (yi >= 2) && (yi < N_PIX);

            n_chk++;
            if (pe_ctrl !== e_ctrl) $display("FAIL %s ctrl cyc%0d: got %b want %b", nm, c, pe_ctrl, e_ctrl);
            else n_pass++;
            n_chk++;
            if ({pe_in1, pe_in2, pe_in3} !== {e_in[0], e_in[1], e_in[2]})
                $display("FAIL %s pe_in cyc%0d: got %h/%h/%h want %h/%h/%h", nm, c, pe_in1, pe_in2, pe_in3, e_in[0], e_in[1], e_in[2]);
            else n_pass++;
            n_chk++;
            if ({px_ready, busy, done, err} !== {e_rdy, e_busy, e_done, e_err})
                $display("FAIL %s status cyc%0d: got rdy/busy/done/err=%b%b%b%b want %b%b%b%b",
                         nm, c, px_ready, busy, done, err, e_rdy, e_busy, e_done, e_err);
            else n_pass++;
            n_chk++;
            if (y_valid !== e_yv) $display("FAIL %s y_valid cyc%0d: got %b want %b", nm, c, y_valid, e_yv);
            else n_pass++;
            if (e_yv) begin
                n_chk++;
                if ({y_data, y_index} !== {fsum[yi], IDX_W'(yi)})
                    $display("FAIL %s y cyc%0d: got data=%h idx=%0d want data=%h idx=%0d", nm, c, y_data, y_index, fsum[yi], yi);
                else n_pass++;
            end
`ifdef CONV_SEQ_STALL_CNT_EN
            n_chk++;
            if (stall_cnt !== 16'(e_stall)) $display("FAIL %s stall_cnt cyc%0d: got %0d want %0d", nm, c, stall_cnt, e_stall);
            else n_pass++;
`endif
            if (y_valid === 1'b1) begin y_seen++; last_y = y_data; end
            if (done === 1'b1) done_seen++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        prev_err   = (inv_cnt != 0);
        prev_stall = inv_cnt;
        frames_done++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; px_valid = 1'b0; pe_res = 8'h00;
        w_row1 = '0; w_row2 = '0; w_row3 = '0; px1 = '0; px2 = '0; px3 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_chk++;
            if ({pe_ctrl, pe_in1, pe_in2, pe_in3, px_ready, busy, done, err, y_valid, y_data, y_index} !== '0)
                $display("FAIL reset_state +%0d: got ctrl=%b busy=%b done=%b err=%b yv=%b yd=%h, want all 0",
                         k, pe_ctrl, busy, done, err, y_valid, y_data);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_unit_weights();
        fill(12'h000, 8'd1);
        run_frame("t1_unit", -1, -1);
        n_chk++;
        if (last_y !== 16'd9 || y_seen != N_PIX - 2)
            $display("FAIL t1_unit_sum: got y=%0d count=%0d want y=9 count=%0d", last_y, y_seen, N_PIX - 2);
        else n_pass++;
    endtask

    task automatic test_double_weights();
        fill(12'h111, 8'd3);
        run_frame("t2_x2", -1, -1);
        n_chk++;
        if (last_y !== 16'd54) $display("FAIL t2_x2_sum: got %0d want 54", last_y);
        else n_pass++;
    endtask

    task automatic test_negate();
        fill(12'h888, 8'd5);
        run_frame("t3_neg", -1, -1);
        n_chk++;
        if (last_y !== 16'hFFD3) $display("FAIL t3_neg_sum: got %h want ffd3", last_y);
        else n_pass++;
    endtask

    task automatic test_underrun();
        fill(12'($urandom), 8'($urandom));
        fvalid[1] = 1'b0;
        run_frame("t4_underrun", -1, -1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++;
            if (err !== 1'b1) $display("FAIL t4_err_sticky +%0d: got %b want 1", k, err);
            else n_pass++;
`ifdef CONV_SEQ_STALL_CNT_EN
            n_chk++;
            if (stall_cnt !== 16'd1) $display("FAIL t4_stall_cnt: got %0d want 1", stall_cnt);
            else n_pass++;
`endif
            @(posedge clk); #1;
        end
        fill(12'h123, 8'd7);
        run_frame("t4_clear", -1, -1);
    endtask

    task automatic test_reset_mid();
        fill(12'h456, 8'd9);
        run_frame("t5_abort", -1, 9);
        fill(12'h000, 8'd1);
        run_frame("t5_after", -1, -1);
        n_chk++;
        if (last_y !== 16'd9) $display("FAIL t5_after_sum: got %0d want 9", last_y);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        int done_before;
        fill(12'h111, 8'd3);
        run_frame("t6_busy_start", 10, -1);
        done_before = done_seen;
        start = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        prev_err = 0; prev_stall = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++;
            if ({busy, done, px_ready, pe_ctrl} !== 7'b0)
                $display("FAIL t6_start_rst +%0d: got busy=%b done=%b rdy=%b ctrl=%b want 0", k, busy, done, px_ready, pe_ctrl);
            else n_pass++;
            @(posedge clk); #1;
        end
        n_chk++;
        if (done_seen != done_before) $display("FAIL t6_frame_count: got %0d want %0d", done_seen, done_before);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            for (int r = 0; r < 3; r++) begin
                fw[r] = 12'($urandom);
                for (int i = 0; i < N_PIX; i++) fpx[r][i] = 8'($urandom);
            end
            for (int i = 0; i < N_PIX; i++) fvalid[i] = ($urandom_range(0, 7) != 0);
            run_frame($sformatf("rand%0d", f), -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_unit_weights();
        test_double_weights();
        test_negate();
        test_underrun();
        test_reset_mid();
        test_start_ignored();
        test_random();
        n_chk++;
        if (done_seen != frames_done) $display("FAIL done_count: got %0d want %0d", done_seen, frames_done);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
